// File: rtl/chunk_read_arbiter_pkg.sv
// Shared block-address and block-type definitions for the chunk lookup path.
package chunk_read_arbiter_pkg;

   typedef struct packed {
      logic signed [15:0] x;
      logic signed [15:0] y;
      logic signed [15:0] z;
   } BlockPos;

   typedef logic [7:0] BlockType;

   localparam BlockType BLOCK_AIR = 8'd0;

endpackage

// File: rtl/chunk_read_arbiter_if.sv
// Requester-side and chunk-side bus of the chunk read arbiter.
interface chunk_read_arbiter_if #(
   parameter int N_REQ = 4
) ();
   import chunk_read_arbiter_pkg::*;

   logic [N_REQ-1:0] req_valid;
   BlockPos          req_addr [N_REQ];
   logic [N_REQ-1:0] req_ready;
   logic [N_REQ-1:0] resp_valid;
   BlockType         resp_block;
   logic             resp_timeout;

   BlockPos          chunk_addr;
   logic             chunk_read_enable;
   BlockType         chunk_out;
   logic             chunk_valid;

   modport slave (
      input  req_valid, req_addr, chunk_out, chunk_valid,
      output req_ready, resp_valid, resp_block, resp_timeout,
             chunk_addr, chunk_read_enable
   );

   modport master (
      output req_valid, req_addr, chunk_out, chunk_valid,
      input  req_ready, resp_valid, resp_block, resp_timeout,
             chunk_addr, chunk_read_enable
   );

endinterface

// File: rtl/chunk_read_arbiter.sv
// Round-robin arbiter sharing one chunk block-lookup port between N_REQ requesters.
// One request is in flight at a time; its address is held on the chunk port until valid or timeout.
module chunk_read_arbiter
   import chunk_read_arbiter_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   chunk_read_arbiter_if.slave  bus,
   output logic                 busy,
   output logic [31:0]          served_count
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

   typedef enum logic {
      IDLE,
      ISSUE
   } state_t;

   state_t           state, state_d;
   logic [PTR_W-1:0] rr_ptr, rr_ptr_d;
   logic [PTR_W-1:0] grant_q, grant_d;
   logic [PTR_W-1:0] winner, scan_idx;
   logic             has_winner;
   BlockPos          addr_q, addr_d;
   logic [CNT_W-1:0] wait_cnt, wait_d;
   BlockType         resp_block_q, resp_block_d;
   logic [N_REQ-1:0] resp_valid_q, resp_valid_d;
   logic             resp_timeout_q, resp_timeout_d;
   logic [31:0]      served_q, served_d;
   logic [N_REQ-1:0] ready_c;
   logic             read_enable_c;

   // Scan downwards so the last hit, which wins, is the first requester at or after rr_ptr.
   always_comb begin
      has_winner = 1'b0;
      winner     = '0;
      scan_idx   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         scan_idx = PTR_W'((int'(rr_ptr) + k) % N_REQ);
         if (bus.req_valid[scan_idx]) begin
            has_winner = 1'b1;
            winner     = scan_idx;
         end
      end
   end

   always_comb begin
      state_d        = state;
      rr_ptr_d       = rr_ptr;
      grant_d        = grant_q;
      addr_d         = addr_q;
      wait_d         = wait_cnt;
      resp_block_d   = resp_block_q;
      resp_valid_d   = '0;
      resp_timeout_d = 1'b0;
      served_d       = served_q;
      ready_c        = '0;
      read_enable_c  = 1'b0;

      case (state)
         IDLE: begin
            if (has_winner) begin
               ready_c  = ONE_HOT0 << winner;
               addr_d   = bus.req_addr[winner];
               grant_d  = winner;
               rr_ptr_d = (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
               wait_d   = '0;
               state_d  = ISSUE;
            end
         end

         ISSUE: begin
            read_enable_c = 1'b1;
            wait_d        = wait_cnt + 1'b1;
            // A valid that arrives on the last allowed cycle still counts as a real answer.
            if (bus.chunk_valid) begin
               resp_block_d = bus.chunk_out;
               resp_valid_d = ONE_HOT0 << grant_q;
               served_d     = served_q + 32'd1;
               state_d      = IDLE;
            end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
               resp_block_d   = BLOCK_AIR;
               resp_valid_d   = ONE_HOT0 << grant_q;
               resp_timeout_d = 1'b1;
               served_d       = served_q + 32'd1;
               state_d        = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         rr_ptr         <= '0;
         grant_q        <= '0;
         addr_q         <= '0;
         wait_cnt       <= '0;
         resp_block_q   <= BLOCK_AIR;
         resp_valid_q   <= '0;
         resp_timeout_q <= 1'b0;
         served_q       <= '0;
      end else begin
         rr_ptr         <= rr_ptr_d;
         grant_q        <= grant_d;
         addr_q         <= addr_d;
         wait_cnt       <= wait_d;
         resp_block_q   <= resp_block_d;
         resp_valid_q   <= resp_valid_d;
         resp_timeout_q <= resp_timeout_d;
         served_q       <= served_d;
      end
   end

   // The chunk address is never gated so the chunk's own address pipe stays settled between requests.
   assign bus.chunk_addr        = addr_q;
   assign bus.chunk_read_enable = read_enable_c;
   assign bus.req_ready         = ready_c;
   assign bus.resp_valid        = resp_valid_q;
   assign bus.resp_block        = resp_block_q;
   assign bus.resp_timeout      = resp_timeout_q;
   assign busy                  = (state != IDLE);
   assign served_count          = served_q;

endmodule

// File: tb/tb_chunk_read_arbiter.sv
// Scoreboard bench for chunk_read_arbiter with a behavioural chunk ROM and arbitration model.
module tb_chunk_read_arbiter;
   import chunk_read_arbiter_pkg::*;

   localparam int N_REQ        = 4;
   localparam int TIMEOUT      = 15;
   localparam int CHUNK_WIDTH  = 40;
   localparam int CHUNK_HEIGHT = 64;
   localparam int CHUNK_DEPTH  = 40;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        busy;
   logic [31:0] served_count;

   chunk_read_arbiter_if #(.N_REQ(N_REQ)) bus ();

   chunk_read_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .bus         (bus.slave),
      .busy        (busy),
      .served_count(served_count)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      int       req;
      BlockType block;
      bit       timeout;
      longint   due;
   } exp_t;

   exp_t             sb[$];
   int               tests = 0;
   int               fails = 0;
   longint           cycle = 0;
   int               model_rr = 0;
   longint           idle_from = 0;
   BlockPos          model_prev = '0;
   int               model_served = 0;
   int               resp_per_req [N_REQ];
   int               grants = 0;
   logic [N_REQ-1:0] granted_mask = '0;
   bit               chunk_dead = 1'b0;
   BlockPos          pipe1 = '0;
   BlockPos          pipe2 = '0;

   function automatic bit in_bounds(BlockPos p);
      int x, y, z;
      x = int'(p.x);
      y = int'(p.y);
      z = int'(p.z);
      return (x >= 0 && x < CHUNK_WIDTH && y >= 0 && y < CHUNK_HEIGHT && z >= 0 && z < CHUNK_DEPTH);
   endfunction

   function automatic BlockType rom_data(BlockPos p);
      int x, y, z;
      x = int'(p.x);
      y = int'(p.y);
      z = int'(p.z);
      if (!in_bounds(p)) return BLOCK_AIR;
      return BlockType'(((x * 7 + y * 13 + z * 3) % 250) + 1);
   endfunction

   function automatic BlockPos mkPos(int x, int y, int z);
      BlockPos p;
      p.x = 16'(x);
      p.y = 16'(y);
      p.z = 16'(z);
      return p;
   endfunction

   function automatic BlockPos randomAddr();
      BlockPos p;
      int sel;
      sel = int'($urandom_range(9, 0));
      p = mkPos(int'($urandom_range(CHUNK_WIDTH - 1, 0)),
                int'($urandom_range(CHUNK_HEIGHT - 1, 0)),
                int'($urandom_range(CHUNK_DEPTH - 1, 0)));
      if (sel < 2) begin
         p = model_prev;
      end else if (sel < 4) begin
         case ($urandom_range(2, 0))
            0:       p.x = 16'(CHUNK_WIDTH + int'($urandom_range(5, 0)));
            1:       p.y = 16'(-1 - int'($urandom_range(5, 0)));
            default: p.z = 16'(CHUNK_DEPTH);
         endcase
      end
      return p;
   endfunction

   // Chunk ROM: out-of-range answers at once; in-range needs the address stable for two edges.
   always @(posedge clk_in) begin
      pipe1 <= bus.chunk_addr;
      pipe2 <= pipe1;
   end

   always_comb begin
      bus.chunk_out   = rom_data(bus.chunk_addr);
      bus.chunk_valid = !chunk_dead && bus.chunk_read_enable &&
                        (!in_bounds(bus.chunk_addr) ||
                         (pipe1 == bus.chunk_addr && pipe2 == bus.chunk_addr));
   end

   always @(posedge clk_in) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   task automatic failNow(input string name);
      tests++;
      fails++;
      $display("[TB] FAIL %s: not reached within its cycle budget (cycle %0d)", name, cycle);
   endtask

   task automatic resetModel();
      sb.delete();
      model_rr     = 0;
      idle_from    = 0;
      model_prev   = '0;
      model_served = 0;
      granted_mask = '0;
   endtask

   // Monitor: predicts grants from the round-robin rule, pushes expected responses, pops on resp_valid.
   always @(negedge clk_in) begin
      logic [N_REQ-1:0] exp_ready;
      int               win;
      int               lat;
      bit               idle;
      exp_t             e;
      BlockPos          a;
      if (!rst_in) begin
         granted_mask = '0;
         idle         = (cycle >= idle_from);
         exp_ready    = '0;
         win          = -1;

         if (bus.resp_valid != '0) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_resp", 64'(bus.resp_valid), 64'(0));
            end else begin
               e = sb.pop_front();
               checkOutput("resp_valid", 64'(bus.resp_valid), 64'(1) << e.req);
               checkOutput("resp_block", 64'(bus.resp_block), 64'(e.block));
               checkOutput("resp_timeout", 64'(bus.resp_timeout), 64'(e.timeout));
               checkOutput("resp_cycle", 64'(cycle), 64'(e.due));
               model_served++;
               checkOutput("served_count", 64'(served_count), 64'(32'(model_served)));
               resp_per_req[e.req]++;
            end
         end else begin
            checkOutput("resp_timeout_idle", 64'(bus.resp_timeout), 64'(0));
            if (sb.size() != 0 && sb[0].due <= cycle) begin
               tests++;
               fails++;
               $display("[TB] FAIL missing_resp: no response, required requester %0d at cycle %0d", sb[0].req, sb[0].due);
               void'(sb.pop_front());
            end
         end

         if (idle) begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
               if (bus.req_valid[(model_rr + k) % N_REQ]) win = (model_rr + k) % N_REQ;
            end
         end
         if (win >= 0) exp_ready[win] = 1'b1;
         checkOutput("req_ready", 64'(bus.req_ready), 64'(exp_ready));
         checkOutput("busy", 64'(busy), 64'(!idle));

         if (win >= 0) begin
            a = bus.req_addr[win];
            if (chunk_dead)                           lat = TIMEOUT + 1;
            else if (!in_bounds(a) || a == model_prev) lat = 1;
            else                                      lat = 3;
            e.req     = win;
            e.block   = chunk_dead ? BLOCK_AIR : rom_data(a);
            e.timeout = chunk_dead;
            e.due     = cycle + 1 + longint'(lat);
            sb.push_back(e);
            model_rr          = (win + 1) % N_REQ;
            idle_from         = e.due;
            model_prev        = a;
            grants++;
            granted_mask[win] = 1'b1;
         end
      end
   end

   task automatic applyStimulus();
      for (int i = 0; i < N_REQ; i++) begin
         if (bus.req_valid[i] && granted_mask[i]) begin
            if ($urandom_range(1, 0) == 1) bus.req_addr[i] = randomAddr();
            else                           bus.req_valid[i] = 1'b0;
         end else if (!bus.req_valid[i] && $urandom_range(2, 0) == 0) begin
            bus.req_addr[i]  = randomAddr();
            bus.req_valid[i] = 1'b1;
         end
      end
   endtask

   task automatic requestOne(input int idx, input BlockPos a);
      bit ok;
      ok = 1'b0;
      bus.req_addr[idx]  = a;
      bus.req_valid[idx] = 1'b1;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(posedge clk_in);
         #1;
         if (granted_mask[idx]) ok = 1'b1;
      end
      bus.req_valid[idx] = 1'b0;
      if (!ok) failNow("grant_wait");
   endtask

   task automatic waitIdle();
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 300 && !ok; n++) begin
         @(posedge clk_in);
         #1;
         if (sb.size() == 0 && !busy) ok = 1'b1;
      end
      if (!ok) failNow("drain_timeout");
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int  base;
      int  base_cnt [N_REQ];
      bit  done;

      bus.req_valid = '0;
      for (int i = 0; i < N_REQ; i++) bus.req_addr[i] = '0;
      rst_in = 1'b1;
      repeat (3) @(posedge clk_in);
      #1;
      checkOutput("reset_busy", 64'(busy), 64'(0));
      checkOutput("reset_served", 64'(served_count), 64'(0));
      checkOutput("reset_resp_valid", 64'(bus.resp_valid), 64'(0));
      checkOutput("reset_read_enable", 64'(bus.chunk_read_enable), 64'(0));
      checkOutput("reset_chunk_addr", 64'(bus.chunk_addr), 64'(0));
      #1;
      rst_in = 1'b0;
      resetModel();
      repeat (3) @(posedge clk_in);
      #1;

      requestOne(0, mkPos(1, 2, 3));
      waitIdle();
      checkOutput("served_after_first", 64'(served_count), 64'(1));

      requestOne(1, mkPos(40, 0, 0));
      waitIdle();

      requestOne(2, mkPos(5, 5, 5));
      requestOne(2, mkPos(5, 5, 5));
      waitIdle();

      for (int i = 0; i < N_REQ; i++) begin
         base_cnt[i]      = resp_per_req[i];
         bus.req_addr[i]  = randomAddr();
         bus.req_valid[i] = 1'b1;
      end
      base = grants;
      done = 1'b0;
      for (int n = 0; n < 1000 && !done; n++) begin
         @(posedge clk_in);
         #1;
         for (int i = 0; i < N_REQ; i++) begin
            if (granted_mask[i]) bus.req_addr[i] = randomAddr();
         end
         if (grants - base >= 20) begin
            bus.req_valid = '0;
            done = 1'b1;
         end
      end
      bus.req_valid = '0;
      if (!done) failNow("fairness_grants");
      waitIdle();
      for (int i = 0; i < N_REQ; i++) begin
         checkOutput("fair_count", 64'(resp_per_req[i] - base_cnt[i]), 64'(5));
      end

      chunk_dead = 1'b1;
      requestOne(3, mkPos(7, 8, 9));
      waitIdle();
      requestOne(0, mkPos(-1, 0, 0));
      waitIdle();
      chunk_dead = 1'b0;
      requestOne(1, mkPos(7, 8, 9));
      waitIdle();

      for (int n = 0; n < 800; n++) begin
         @(posedge clk_in);
         #1;
         applyStimulus();
      end
      bus.req_valid = '0;
      waitIdle();

      bus.req_addr[1]  = mkPos(11, 22, 33);
      bus.req_valid[1] = 1'b1;
      done = 1'b0;
      for (int n = 0; n < 50 && !done; n++) begin
         @(posedge clk_in);
         #1;
         if (busy) done = 1'b1;
      end
      bus.req_valid[1] = 1'b0;
      if (!done) failNow("issue_before_reset");
      #1;
      rst_in = 1'b1;
      resetModel();
      #1;
      checkOutput("midreset_busy", 64'(busy), 64'(0));
      checkOutput("midreset_read_enable", 64'(bus.chunk_read_enable), 64'(0));
      checkOutput("midreset_resp_valid", 64'(bus.resp_valid), 64'(0));
      for (int i = 0; i < N_REQ; i++) bus.req_addr[i] = randomAddr();
      bus.req_valid = '1;
      @(posedge clk_in);
      #2;
      rst_in = 1'b0;
      resetModel();
      @(negedge clk_in);
      #1;
      checkOutput("post_reset_grant", 64'(bus.req_ready), 64'(4'b0001));
      @(posedge clk_in);
      #1;
      bus.req_valid = '0;
      waitIdle();

      checkOutput("scoreboard_empty", 64'(sb.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
